button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Input-side counterpart to the LED drivers: samples a raw, bouncing push-button pin in the
//  CLK25MHZ domain (clk_wiz_0 output). Emits a clean level, one-cycle press/release strobes and
//  a one-shot long-press strobe. Sits between the board pin and user logic: mode select, reset request.
// PARAMETERS
//  SYNC_STAGES      2           synchronizer flops on btn_raw (>=2)
//  DEBOUNCE_CYCLES  250_000     consecutive stable cycles needed to accept a change (10 ms @ 25 MHz, >=1)
//  HOLD_CYCLES      25_000_000  cycles of accepted press before btn_long fires (1 s @ 25 MHz, >=1)
// PORTS
//  CLK25MHZ     in   1  system clock, 25 MHz
//  ck_rst       in   1  asynchronous reset, active-high
//  btn_raw      in   1  raw button pin, asynchronous, 1 = pressed
//  btn_level    out  1  debounced level, registered
//  btn_press    out  1  1-cycle strobe on accepted 0->1
//  btn_release  out  1  1-cycle strobe on accepted 1->0
//  btn_long     out  1  1-cycle strobe once per press, after HOLD_CYCLES held
// BEHAVIOUR
//  - Reset (async assert, sync release): synchronizer flops, counters and all outputs = 0; FSM = S_LOW.
//  - btn_raw passes through SYNC_STAGES flops -> btn_sync. All logic below uses btn_sync only.
//  - FSM states: S_LOW, S_RISE, S_HIGH, S_FALL. btn_level = 1 in S_HIGH and S_FALL.
//    S_LOW : btn_sync=1 -> S_RISE, db_cnt <= 1.
//    S_RISE: btn_sync=0 -> S_LOW (glitch rejected, no strobe).
//            btn_sync=1 and db_cnt==DEBOUNCE_CYCLES -> S_HIGH; btn_press=1 for 1 cycle; hold_cnt <= 0.
//            Otherwise db_cnt++.
//    S_HIGH: btn_sync=0 -> S_FALL, db_cnt <= 1. hold_cnt++ saturating at HOLD_CYCLES.
//            btn_long=1 on the cycle hold_cnt first reaches HOLD_CYCLES.
//    S_FALL: btn_sync=1 -> S_HIGH (glitch rejected). hold_cnt keeps counting, so a bounce does not
//            restart the long-press timer.
//            btn_sync=0 and db_cnt==DEBOUNCE_CYCLES -> S_LOW; btn_release=1 for 1 cycle.
//  - Latency: btn_press rises SYNC_STAGES+DEBOUNCE_CYCLES+1 clock edges after btn_raw rises and stays
//    stable. btn_release has the same latency.
//  - Counter widths: db_cnt is $clog2(DEBOUNCE_CYCLES+1) bits; hold_cnt is $clog2(HOLD_CYCLES+1) bits.
//    Neither counter can wrap: db_cnt is bounded by the FSM and hold_cnt saturates.
//  - btn_long fires at most once per accepted press, never after release. A release accepted on the
//    same cycle hold_cnt would reach HOLD_CYCLES suppresses btn_long.
//  - btn_press, btn_release and btn_long are mutually exclusive. None assert during or in the first
//    cycle after reset.
//  - Button held through reset: comes up in S_LOW and produces a normal btn_press after debounce.
//    No spurious release.
//  - Reset mid-debounce or mid-hold: everything aborts. No strobe is emitted for the aborted event.
// STRUCTURE
//  - Shared package btn_pkg: typedef enum logic [1:0] {S_LOW,S_RISE,S_HIGH,S_FALL} btn_state_t;
//    default constants for 25 MHz timing.
//  - One sub-module, sync_ff #(.STAGES) (CLK25MHZ, ck_rst, d, q), reused for other board inputs.
//  - Single always_ff for FSM and counters. Outputs are registered, with no combinational path
//    from btn_raw.
// TESTING  (bench parameters: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10)
//  1. Reset, then btn_raw=1 held -> btn_press pulses exactly at edge 2+4+1=7. btn_level=1 from then on.
//  2. btn_raw pulses high for 3 cycles, then 0 -> no strobes; btn_level stays 0; FSM returns to S_LOW.
//  3. Press accepted, then bounce 1-0-1-0-1 (1-cycle glitches) and hold -> single btn_press,
//     no btn_release.
//  4. Press held 20 cycles -> btn_long exactly once, 10 cycles after btn_press. Release -> one
//     btn_release 7 cycles after the falling edge.
//  5. Press, release after 5 held cycles -> btn_press and btn_release only, no btn_long.
//  6. ck_rst asserted mid-S_RISE and mid-S_HIGH -> outputs 0 immediately (async). Button still
//     held -> fresh btn_press 7 cycles after reset release.

Source files
------------

// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
//   Shared types and default timing for the push-button input path.
//   - btn_state_t : debouncer FSM state encoding
//   - DEF_*       : defaults for a 25 MHz system clock
//   - cnt_width() : bits needed for a counter that must hold 0..max_val
// -----------------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_RISE = 2'd1,
    S_HIGH = 2'd2,
    S_FALL = 2'd3
  } btn_state_t;

  localparam int unsigned DEF_SYNC_STAGES     = 32'd2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 32'd250_000;     // 10 ms @ 25 MHz
  localparam int unsigned DEF_HOLD_CYCLES     = 32'd25_000_000;  // 1 s  @ 25 MHz

  // Counter width able to represent max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    if (max_val < 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(max_val + 32'd1);
    end
  endfunction

endpackage

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
//   Multi-flop synchronizer for an asynchronous single-bit board input.
//   Ports:
//     CLK25MHZ  in  destination clock
//     ck_rst    in  asynchronous reset, active-high (clears every stage)
//     d         in  asynchronous input
//     q         out synchronized output (last stage)
//   STAGES must be >= 2.
// -----------------------------------------------------------------------------
module sync_ff #(
  parameter int unsigned STAGES = 32'd2
) (
  input  logic CLK25MHZ,
  input  logic ck_rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the synchronizer chain.
  always_ff @(posedge CLK25MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
//   Turns a bouncing push-button pin into a clean level plus one-cycle
//   press / release / long-press strobes, all in the CLK25MHZ domain.
//   Ports:
//     CLK25MHZ     in  system clock
//     ck_rst       in  asynchronous reset, active-high
//     btn_raw      in  raw button pin, asynchronous, 1 = pressed
//     btn_level    out debounced level (registered)
//     btn_press    out 1-cycle strobe on an accepted 0->1
//     btn_release  out 1-cycle strobe on an accepted 1->0
//     btn_long     out 1-cycle strobe once per press after HOLD_CYCLES held
//   A change is accepted only after DEBOUNCE_CYCLES+1 consecutive samples of
//   the new value on the synchronized input; any contrary sample aborts it.
// -----------------------------------------------------------------------------
module button_debounce
  import btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic CLK25MHZ,
  input  logic ck_rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int unsigned DB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned HOLD_W = cnt_width(HOLD_CYCLES);

  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 32'd1);

  logic              btn_sync;
  btn_state_t        state_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              level_q;
  logic              press_q;
  logic              release_q;
  logic              long_q;

  logic db_done;
  logic hold_sat;
  logic hold_last;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .CLK25MHZ (CLK25MHZ),
    .ck_rst   (ck_rst),
    .d        (btn_raw),
    .q        (btn_sync)
  );

  assign db_done   = (db_cnt_q == DB_MAX);
  assign hold_sat  = (hold_cnt_q == HOLD_MAX);
  // The increment on this cycle takes hold_cnt to HOLD_CYCLES for the first time.
  assign hold_last = (hold_cnt_q == HOLD_LAST);

  // Debounce FSM, debounce/hold counters and registered strobes.
  always_ff @(posedge CLK25MHZ or posedge ck_rst) begin
    if (ck_rst) begin
      state_q    <= S_LOW;
      db_cnt_q   <= '0;
      hold_cnt_q <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      case (state_q)
        S_LOW: begin
          hold_cnt_q <= '0;
          if (btn_sync) begin
            state_q  <= S_RISE;
            db_cnt_q <= DB_ONE;
          end
        end
        S_RISE: begin
          if (!btn_sync) begin
            state_q <= S_LOW;
          end else if (db_done) begin
            state_q    <= S_HIGH;
            level_q    <= 1'b1;
            press_q    <= 1'b1;
            hold_cnt_q <= '0;
          end else begin
            db_cnt_q <= db_cnt_q + DB_ONE;
          end
        end
        S_HIGH: begin
          if (!hold_sat) begin
            hold_cnt_q <= hold_cnt_q + HOLD_ONE;
          end
          long_q <= hold_last;
          if (!btn_sync) begin
            state_q  <= S_FALL;
            db_cnt_q <= DB_ONE;
          end
        end
        S_FALL: begin
          if (!btn_sync && db_done) begin
            // Accepted release wins over a long-press due on this same cycle.
            state_q   <= S_LOW;
            level_q   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            // Timer keeps running through bounces so they cannot restart it.
            if (!hold_sat) begin
              hold_cnt_q <= hold_cnt_q + HOLD_ONE;
            end
            long_q <= hold_last;
            if (btn_sync) begin
              state_q <= S_HIGH;
            end else begin
              db_cnt_q <= db_cnt_q + DB_ONE;
            end
          end
        end
        default: begin
          state_q <= S_LOW;
          level_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: tb/tb_button_debounce.sv
// -----------------------------------------------------------------------------
// tb_button_debounce
//   Self-checking bench for button_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
//   HOLD_CYCLES=10). A reference model derived from the acceptance rules is
//   compared against all four outputs every cycle; directed scenarios add
//   hand-computed latency and strobe-count expectations; a random phase
//   follows.
// -----------------------------------------------------------------------------
module tb_button_debounce;

  localparam int S = 2;
  localparam int D = 4;
  localparam int H = 10;

  logic clk = 1'b0;
  logic rst;
  logic raw;
  logic lvl, prs, rls, lng;

  always #20 clk = ~clk;

  button_debounce #(
    .SYNC_STAGES     (S),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H)
  ) dut (
    .CLK25MHZ    (clk),
    .ck_rst      (rst),
    .btn_raw     (raw),
    .btn_level   (lvl),
    .btn_press   (prs),
    .btn_release (rls),
    .btn_long    (lng)
  );

  int vectors     = 0;
  int miscompares = 0;
  int edge_n      = 0;

  // Reference model state
  bit m_sh [S];
  bit m_lvl;
  int m_run;   // consecutive samples disagreeing with the accepted level
  int m_hold;  // edges held since the accepted press
  bit m_prs, m_rls, m_lng;

  // Observations of the DUT
  int n_prs = 0, n_rls = 0, n_lng = 0;
  int last_prs_edge = 0, last_rls_edge = 0, last_lng_edge = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < S; i++) m_sh[i] = 1'b0;
    m_lvl  = 1'b0;
    m_run  = 0;
    m_hold = 0;
    m_prs  = 1'b0;
    m_rls  = 1'b0;
    m_lng  = 1'b0;
  endtask

  // One clock edge: a change is accepted on its (D+1)-th consecutive sample.
  task automatic model_step(input bit r);
    bit s;
    bit acc;
    s = m_sh[S-1];
    for (int i = S - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
    m_sh[0] = r;
    m_prs = 1'b0;
    m_rls = 1'b0;
    m_lng = 1'b0;
    acc = (s != m_lvl) && (m_run == D);
    if (s != m_lvl) m_run = acc ? 0 : m_run + 1;
    else            m_run = 0;
    if (m_lvl && m_hold < H) begin
      m_hold++;
      if (m_hold == H && !acc) m_lng = 1'b1;
    end
    if (acc) begin
      m_lvl  = !m_lvl;
      m_prs  = m_lvl;
      m_rls  = !m_lvl;
      m_hold = 0;
    end
  endtask

  task automatic compare_outputs();
    check("outputs{level,press,release,long}", {28'd0, lvl, prs, rls, lng},
          {28'd0, m_lvl, m_prs, m_rls, m_lng});
    if (prs === 1'b1) begin n_prs++; last_prs_edge = edge_n; end
    if (rls === 1'b1) begin n_rls++; last_rls_edge = edge_n; end
    if (lng === 1'b1) begin n_lng++; last_lng_edge = edge_n; end
  endtask

  // Called at a falling edge: apply r, take one rising edge, check at next fall.
  task automatic cycle(input bit r);
    raw = r;
    @(posedge clk);
    model_step(r);
    edge_n++;
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic run(input bit r, input int n);
    repeat (n) cycle(r);
  endtask

  // Assert reset between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("async_reset_outputs", {28'd0, lvl, prs, rls, lng}, 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  int base, fall, p0, r0, l0;
  bit rr;
  int nn;

  initial begin
    rst = 1'b1;
    raw = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {28'd0, lvl, prs, rls, lng}, 32'd0);
    rst = 1'b0;

    // 1: steady press -> press strobe on the 7th edge, level stays high
    base = edge_n; p0 = n_prs;
    run(1'b1, 12);
    check("t1_press_latency", last_prs_edge - base, 32'd7);
    check("t1_press_count", n_prs - p0, 32'd1);
    check("t1_level_high", {31'd0, lvl}, 32'd1);
    run(1'b0, 10);

    // 2: 3-cycle pulse is rejected
    p0 = n_prs; r0 = n_rls;
    run(1'b1, 3);
    run(1'b0, 8);
    check("t2_no_press", n_prs - p0, 32'd0);
    check("t2_no_release", n_rls - r0, 32'd0);
    check("t2_level_low", {31'd0, lvl}, 32'd0);

    // 3: bounce after an accepted press gives one press, no release
    p0 = n_prs; r0 = n_rls;
    run(1'b1, 9);
    cycle(1'b0); cycle(1'b1); cycle(1'b0); cycle(1'b1);
    run(1'b1, 4);
    check("t3_single_press", n_prs - p0, 32'd1);
    check("t3_no_release", n_rls - r0, 32'd0);
    run(1'b0, 10);

    // 4: long hold -> long strobe 10 edges after press, release 7 after fall
    p0 = n_prs; r0 = n_rls; l0 = n_lng;
    run(1'b1, 22);
    fall = edge_n;
    run(1'b0, 10);
    check("t4_long_count", n_lng - l0, 32'd1);
    check("t4_long_after_press", last_lng_edge - last_prs_edge, 32'd10);
    check("t4_release_latency", last_rls_edge - fall, 32'd7);
    check("t4_release_count", n_rls - r0, 32'd1);

    // 5: release accepted exactly when the hold timer would expire
    p0 = n_prs; r0 = n_rls; l0 = n_lng;
    run(1'b1, 10);
    fall = edge_n;
    run(1'b0, 10);
    check("t5_press_count", n_prs - p0, 32'd1);
    check("t5_release_count", n_rls - r0, 32'd1);
    check("t5_no_long", n_lng - l0, 32'd0);
    check("t5_release_latency", last_rls_edge - fall, 32'd7);

    // 6: reset mid-debounce and mid-hold with the button still held
    p0 = n_prs; r0 = n_rls;
    run(1'b1, 4);
    do_reset();
    check("t6_no_press_aborted", n_prs - p0, 32'd0);
    base = edge_n;
    run(1'b1, 10);
    check("t6_press_after_reset1", last_prs_edge - base, 32'd7);
    run(1'b1, 5);
    do_reset();
    base = edge_n;
    run(1'b1, 10);
    check("t6_press_after_reset2", last_prs_edge - base, 32'd7);
    check("t6_no_spurious_release", n_rls - r0, 32'd0);
    run(1'b0, 10);

    // Random bursts of mixed lengths with occasional resets
    for (int i = 0; i < 160; i++) begin
      rr = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       nn = int'($urandom_range(1, 4));
        1:       nn = int'($urandom_range(15, 30));
        default: nn = int'($urandom_range(1, 12));
      endcase
      run(rr, nn);
      if ($urandom_range(0, 24) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
